// File: rtl/seq_booth_multiply.sv
// Multi-cycle radix-4 Booth multiplier with a start/busy/done handshake. It handles signed or unsigned operands, selected per operation.
// Optional SEQ_BOOTH_ZERO_SKIP_EN: a zero operand skips RUN and completes one cycle after acceptance.
module seq_booth_multiply #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int N  = WIDTH / 2 + 1;
    localparam int EW = WIDTH + 2;
    localparam int AW = 2 * WIDTH + 4;
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state;
    logic [EW-1:0]   mcand;
    logic [EW:0]     mplier;
    logic [AW-1:0]   acc;
    logic [CW-1:0]   cnt;

    logic [EW-1:0]   ext_a;
    logic [EW-1:0]   ext_b;
    logic [AW-1:0]   m_ext;
    logic [AW-1:0]   digit;
    logic [AW-1:0]   acc_next;

    always_comb begin
        ext_a = signed_mode ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
        ext_b = signed_mode ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};
        m_ext = {{(AW-EW){mcand[EW-1]}}, mcand};
        // Standard radix-4 recoding of the triplet {b[2i+1], b[2i], b[2i-1]}.
        case (mplier[2:0])
            3'b001, 3'b010: digit = m_ext;
            3'b011:         digit = m_ext << 1;
            3'b100:         digit = -(m_ext << 1);
            3'b101, 3'b110: digit = -m_ext;
            default:        digit = '0;
        endcase
        acc_next = acc + (digit << {cnt, 1'b0});
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
        end else begin
            // NOTE: done defaults low every cycle so it can only ever be a single-cycle pulse.
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= ext_a;
                        mplier <= {ext_b, 1'b0};
                        acc    <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
`ifdef SEQ_BOOTH_ZERO_SKIP_EN
                        if (a == '0 || b == '0) begin
                            state   <= DONE;
                            product <= '0;
                            done    <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
`else
                        state <= RUN;
`endif
                    end
                end
                RUN: begin
                    acc    <= acc_next;
                    mplier <= {{2{mplier[EW]}}, mplier[EW:2]};
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(N - 1)) begin
                        state   <= DONE;
                        product <= acc_next[2*WIDTH-1:0];
                        done    <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_booth_multiply.sv
// Self-checking bench for seq_booth_multiply (WIDTH = 32). It uses a product scoreboard and checks latency and busy width.
// The expected latency of zero-operand cases follows SEQ_BOOTH_ZERO_SKIP_EN.
module tb_seq_booth_multiply;

    localparam int W   = 32;
    localparam int LAT = 18;

    logic            clk = 1'b0;
    logic            clr_n;
    logic            start;
    logic            signed_mode;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic            busy;
    logic            done;
    logic [2*W-1:0]  product;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;
    int n_push  = 0;
    logic [2*W-1:0] sb_q[$];

    seq_booth_multiply #(.WIDTH(W)) dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .start       (start),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .product     (product)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic sm);
        logic [2*W-1:0] ex;
        logic [2*W-1:0] ey;
        ex = sm ? {{W{x[W-1]}}, x} : {{W{1'b0}}, x};
        ey = sm ? {{W{y[W-1]}}, y} : {{W{1'b0}}, y};
        return ex * ey;
    endfunction

    // Product comparison happens mid-cycle whenever done is seen.
    always @(negedge clk) begin
        if (clr_n && done) begin
            n_done++;
            if (sb_q.size() == 0) check("unexpected_done", 64'd1, 64'd0);
            else check("product", product, sb_q.pop_front());
        end
    end

    // Drives one start; returns #1 after the accepting edge with start released and inputs scrambled.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic sm,
                         input bit push);
        @(negedge clk);
        a = x; b = y; signed_mode = sm; start = 1'b1;
        if (push) begin
            sb_q.push_back(model(x, y, sm));
            n_push++;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom; b = $urandom; signed_mode = 1'($urandom);
    endtask

    task automatic wait_done(output int lat, output int busy_n);
        lat = 0;
        busy_n = 0;
        for (int i = 1; i <= 64; i++) begin
            if (busy) busy_n++;
            if (done) begin
                lat = i;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic sm, input int exp_lat);
        int lat;
        int busy_n;
        issue(x, y, sm, 1'b1);
        wait_done(lat, busy_n);
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_busy_cycles"}, 64'(busy_n), 64'(exp_lat));
        @(posedge clk);
        #1;
        check({tag, "_done_width"}, 64'(done), 64'd0);
        check({tag, "_idle_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int lat;
        int busy_n;
        int zero_lat;
        logic [2*W-1:0] held;

`ifdef SEQ_BOOTH_ZERO_SKIP_EN
        zero_lat = 1;
`else
        zero_lat = LAT;
`endif
        clr_n = 1'b0; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
        #3;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_product", product, 64'd0);
        @(negedge clk);
        clr_n = 1'b1;

        run_op("s7xm3", 32'd7, 32'hFFFF_FFFD, 1'b1, LAT);
        run_op("u_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, LAT);
        run_op("s_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, LAT);
        run_op("s_min_min", 32'h8000_0000, 32'h8000_0000, 1'b1, LAT);
        run_op("s_min_max", 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, LAT);
        run_op("u_min_max", 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, LAT);
        for (int i = 0; i < 6; i++)
            run_op("rand", $urandom, $urandom, 1'($urandom), LAT);

        // A start pulsed while busy must be ignored.
        issue(32'd5, 32'd6, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        a = 32'd9; b = 32'd9; signed_mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, busy_n);
        check("ign_done_seen", 64'(lat != 0), 64'd1);
        repeat (LAT + 4) @(posedge clk);
        #1;
        check("ign_no_second_done_busy", 64'(busy), 64'd0);
        check("ign_product_held", product, 64'h1E);
        run_op("nine_sq", 32'd9, 32'd9, 1'b0, LAT);

        // Asynchronous reset in mid-operation aborts it.
        held = product;
        check("pre_reset_product", held, 64'd81);
        issue(32'd3, 32'd4, 1'b0, 1'b0);
        repeat (6) @(posedge clk);
        #3;
        clr_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_product", product, 64'd0);
        @(negedge clk);
        clr_n = 1'b1;
        lat = 0;
        for (int i = 0; i < LAT + 4; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) lat++;
        end
        check("abort_quiet", 64'(lat), 64'd0);
        run_op("post_rst", 32'd3, 32'd4, 1'b0, LAT);

        run_op("zero_a", 32'd0, 32'h1234_5678, 1'b0, zero_lat);
        run_op("zero_b", 32'hDEAD_BEEF, 32'd0, 1'b1, zero_lat);
        run_op("after_zero", 32'hFFFF_FFF0, 32'd16, 1'b1, LAT);

        repeat (2) @(posedge clk);
        #1;
        check("sb_empty", 64'(sb_q.size()), 64'd0);
        check("done_count", 64'(n_done), 64'(n_push));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
